// File: rtl/branch_predict_resolve.sv
// Purpose: EX-stage branch resolver with a direct-mapped 2-bit BHT; optional stats via `define BHT_STATS_EN.
// Latency: PC_SEL/MISPREDICT/IF_PRED_TAKEN combinational; BHT (and stats) update registered, visible next cycle.
// Backpressure: none; EX_VALID is held low by the pipeline on stall/bubble, which suppresses update and mispredict.
module branch_predict_resolve #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] IF_PC,
    output logic            IF_PRED_TAKEN,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [2:0]      EX_BRANCH_SEL,
    input  logic            EX_ZERO,
    input  logic            EX_LT,
    input  logic            EX_PRED_TAKEN,
    output logic            PC_SEL,
    output logic            MISPREDICT
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]     STAT_BRANCHES,
    output logic [31:0]     STAT_MISPREDICTS
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Branch condition encodings; 110/111 are reserved and behave like "none".
    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_ZERO  = 3'b001;
    localparam logic [2:0] SEL_NZERO = 3'b010;
    localparam logic [2:0] SEL_JUMP  = 3'b011;
    localparam logic [2:0] SEL_LT    = 3'b100;
    localparam logic [2:0] SEL_GE    = 3'b101;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             br_active;
    logic             br_taken;
    logic             upd_en;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;
    logic             unused_pc_bits;

    // Word-aligned PCs: drop the byte offset, no tag so distant PCs alias.
    assign if_idx = IF_PC[IDX_W+1:2];
    assign ex_idx = EX_PC[IDX_W+1:2];

    // Upper PC bits and byte offset do not participate in indexing.
    assign unused_pc_bits = ^{IF_PC[XLEN-1:IDX_W+2], IF_PC[1:0],
                              EX_PC[XLEN-1:IDX_W+2], EX_PC[1:0]};

    // Prediction is the counter MSB; reads see the pre-update value.
    assign IF_PRED_TAKEN = bht[if_idx][1];

    // Decode the condition into "is a real branch" and "condition holds".
    always_comb begin
        br_active = 1'b0;
        br_taken  = 1'b0;
        case (EX_BRANCH_SEL)
            SEL_ZERO:  begin br_active = 1'b1; br_taken = EX_ZERO;  end
            SEL_NZERO: begin br_active = 1'b1; br_taken = ~EX_ZERO; end
            SEL_JUMP:  begin br_active = 1'b1; br_taken = 1'b1;     end
            SEL_LT:    begin br_active = 1'b1; br_taken = EX_LT;    end
            SEL_GE:    begin br_active = 1'b1; br_taken = ~EX_LT;   end
            SEL_NONE:  begin br_active = 1'b0; br_taken = 1'b0;     end
            default:   begin br_active = 1'b0; br_taken = 1'b0;     end
        endcase
    end

    assign upd_en     = EX_VALID & br_active;
    assign PC_SEL     = EX_VALID & br_taken;
    assign MISPREDICT = upd_en & (PC_SEL != EX_PRED_TAKEN);

    // Saturating 2-bit counter step toward the resolved outcome.
    always_comb begin
        ctr_cur  = bht[ex_idx];
        ctr_next = ctr_cur;
        if (PC_SEL) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // BHT state: reset wins over any concurrent update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
        end else if (upd_en) begin
            bht[ex_idx] <= ctr_next;
        end
    end

`ifdef BHT_STATS_EN
    // Saturating event counters, updated on the same edge as the BHT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STAT_BRANCHES    <= 32'd0;
            STAT_MISPREDICTS <= 32'd0;
        end else begin
            if (upd_en && (STAT_BRANCHES != 32'hFFFF_FFFF))
                STAT_BRANCHES <= STAT_BRANCHES + 32'd1;
            if (MISPREDICT && (STAT_MISPREDICTS != 32'hFFFF_FFFF))
                STAT_MISPREDICTS <= STAT_MISPREDICTS + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Purpose: directed-vector bench for branch_predict_resolve with a queue scoreboard.
// Latency: inputs applied 1 time unit after posedge, outputs checked on the following negedge.
// Backpressure: not applicable; one expected entry is queued per driven cycle.
module tb_branch_predict_resolve;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_PC;
    logic        IF_PRED_TAKEN;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic [2:0]  EX_BRANCH_SEL;
    logic        EX_ZERO;
    logic        EX_LT;
    logic        EX_PRED_TAKEN;
    logic        PC_SEL;
    logic        MISPREDICT;
`ifdef BHT_STATS_EN
    logic [31:0] STAT_BRANCHES;
    logic [31:0] STAT_MISPREDICTS;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string name;
        bit    pc_sel;
        bit    mis;
        bit    pred;
    } exp_t;

    exp_t exp_q[$];

    branch_predict_resolve #(
        .XLEN(32), .BHT_ENTRIES(64), .CTR_INIT(2'b01)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IF_PC(IF_PC),
        .IF_PRED_TAKEN(IF_PRED_TAKEN),
        .EX_VALID(EX_VALID),
        .EX_PC(EX_PC),
        .EX_BRANCH_SEL(EX_BRANCH_SEL),
        .EX_ZERO(EX_ZERO),
        .EX_LT(EX_LT),
        .EX_PRED_TAKEN(EX_PRED_TAKEN),
        .PC_SEL(PC_SEL),
        .MISPREDICT(MISPREDICT)
`ifdef BHT_STATS_EN
        ,
        .STAT_BRANCHES(STAT_BRANCHES),
        .STAT_MISPREDICTS(STAT_MISPREDICTS)
`endif
    );

    always #5 CLK = ~CLK;

    // Monitor: pop one expected entry per cycle and compare all three outputs.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (PC_SEL !== e.pc_sel) begin
                tests_failed++;
                $display("FAIL %s pc_sel got %0b expected %0b", e.name, PC_SEL, e.pc_sel);
            end
            tests_run++;
            if (MISPREDICT !== e.mis) begin
                tests_failed++;
                $display("FAIL %s mispredict got %0b expected %0b", e.name, MISPREDICT, e.mis);
            end
            tests_run++;
            if (IF_PRED_TAKEN !== e.pred) begin
                tests_failed++;
                $display("FAIL %s if_pred_taken got %0b expected %0b", e.name, IF_PRED_TAKEN, e.pred);
            end
        end
    end

    task automatic drive(input string name, input bit rst, input bit vld,
                         input logic [31:0] pc, input logic [2:0] sel,
                         input bit z, input bit lt, input bit pred,
                         input logic [31:0] ifpc,
                         input bit e_sel, input bit e_mis, input bit e_pred);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET         = rst;
        EX_VALID      = vld;
        EX_PC         = pc;
        EX_BRANCH_SEL = sel;
        EX_ZERO       = z;
        EX_LT         = lt;
        EX_PRED_TAKEN = pred;
        IF_PC         = ifpc;
        e.name   = name;
        e.pc_sel = e_sel;
        e.mis    = e_mis;
        e.pred   = e_pred;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        RESET = 1'b1; EX_VALID = 1'b0; EX_PC = '0; EX_BRANCH_SEL = 3'b000;
        EX_ZERO = 1'b0; EX_LT = 1'b0; EX_PRED_TAKEN = 1'b0; IF_PC = '0;
        repeat (2) @(posedge CLK);

        //     name            rst vld pc          sel     z  lt pr ifpc        sel mis pred
        drive("rst_pred_0",    0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h0,   0, 0, 0);
        drive("rst_pred_40",   0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h40,  0, 0, 0);
        drive("rst_pred_fc",   0, 0, 32'h0,   3'b000, 0, 0, 0, 32'hFC,  0, 0, 0);
        drive("beq_taken",     0, 1, 32'h100, 3'b001, 1, 0, 0, 32'h100, 1, 1, 0);
        drive("beq_after",     0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h100, 0, 0, 1);
        drive("rst_with_upd",  1, 1, 32'h100, 3'b011, 0, 0, 1, 32'h100, 1, 0, 1);
        drive("post_rst",      0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h100, 0, 0, 0);
`ifdef BHT_STATS_EN
        check_val("stat_br_rst",  STAT_BRANCHES,    32'd0);
        check_val("stat_mis_rst", STAT_MISPREDICTS, 32'd0);
`endif
        drive("t200_jal",      0, 1, 32'h200, 3'b011, 0, 0, 0, 32'h200, 1, 1, 0);
        drive("t200_lt",       0, 1, 32'h200, 3'b100, 0, 1, 1, 32'h200, 1, 0, 1);
        drive("t200_ne",       0, 1, 32'h200, 3'b010, 0, 0, 1, 32'h200, 1, 0, 1);
        drive("t200_ge_sat",   0, 1, 32'h200, 3'b101, 0, 0, 1, 32'h200, 1, 0, 1);
        drive("t200_nt",       0, 1, 32'h200, 3'b001, 0, 0, 1, 32'h200, 0, 1, 1);
        drive("t200_after",    0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h200, 0, 0, 1);
        drive("novld_jal",     0, 0, 32'h300, 3'b011, 1, 1, 0, 32'h300, 0, 0, 1);
        drive("same_cyc_upd",  0, 1, 32'h300, 3'b001, 0, 0, 1, 32'h300, 0, 1, 1);
        drive("same_cyc_next", 0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h300, 0, 0, 0);
        drive("alias_upd_004", 0, 1, 32'h004, 3'b011, 0, 0, 0, 32'h104, 1, 1, 0);
        drive("alias_rd_104",  0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h104, 0, 0, 1);
        drive("rsv_110",       0, 1, 32'h104, 3'b110, 1, 1, 1, 32'h004, 0, 0, 1);
        drive("rsv_111",       0, 1, 32'h104, 3'b111, 1, 1, 0, 32'h004, 0, 0, 1);
        drive("alias_nt_104",  0, 1, 32'h104, 3'b001, 0, 0, 1, 32'h004, 0, 1, 1);
        drive("alias_rd_004",  0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h004, 0, 0, 0);
        drive("alias_jal_004", 0, 1, 32'h004, 3'b011, 0, 0, 0, 32'h004, 1, 1, 0);
        drive("alias_rd2_004", 0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h004, 0, 0, 1);
        drive("sat0_step",     0, 1, 32'h40,  3'b101, 0, 1, 0, 32'h40,  0, 0, 0);
        drive("sat0_hold",     0, 1, 32'h40,  3'b101, 0, 1, 0, 32'h40,  0, 0, 0);
        drive("sat0_up",       0, 1, 32'h40,  3'b011, 0, 0, 0, 32'h40,  1, 1, 0);
        drive("sat0_rd",       0, 0, 32'h0,   3'b000, 0, 0, 0, 32'h40,  0, 0, 0);

        @(posedge CLK);
        #1;
        EX_VALID = 1'b0;
`ifdef BHT_STATS_EN
        check_val("stat_br_end",  STAT_BRANCHES,    32'd12);
        check_val("stat_mis_end", STAT_MISPREDICTS, 32'd7);
`endif
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge CLK);
                budget--;
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain scoreboard left %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
